// File: rtl/booth_seq_mult_if.sv
// rtl/booth_seq_mult_if.sv - request/result bundle for the sequential Booth multiplier (ovf under MULT_OVF_FLAG_EN)
interface booth_seq_mult_if #(
  parameter int WIDTH = 5
);
  logic               start;
  logic [WIDTH-1:0]   Mcand;
  logic [WIDTH-1:0]   Mplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] out;
`ifdef MULT_OVF_FLAG_EN
  logic               ovf;
`endif

  modport master (
    output start, Mcand, Mplier,
    input  busy, done, out
`ifdef MULT_OVF_FLAG_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, Mcand, Mplier,
    output busy, done, out
`ifdef MULT_OVF_FLAG_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/booth_seq_mult.sv
// rtl/booth_seq_mult.sv - radix-2 Booth sequential signed multiplier, one step per clock (optional ovf via MULT_OVF_FLAG_EN)
module booth_seq_mult #(
  parameter int WIDTH = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  booth_seq_mult_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   q;
  logic               q_1;
  logic [WIDTH-1:0]   mcand;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod_r;
  logic [WIDTH:0]     mc_ext;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_fin;
  logic               accept;

  assign accept   = bus.start && (state != RUN);
  assign mc_ext   = {mcand[WIDTH-1], mcand};
  assign prod_fin = {acc[WIDTH-1:0], q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.start ? RUN : IDLE;
      RUN:     state_nxt = (cnt == '0) ? DONE : RUN;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
    bus.out  = prod_r;
  end

  // The accumulator carries one guard bit so that subtracting the most-negative multiplicand cannot wrap.
  always_comb begin
    case ({q[0], q_1})
      2'b01:   sum = acc + mc_ext;
      2'b10:   sum = acc - mc_ext;
      default: sum = acc;
    endcase
  end

  // The cycle with cnt==0 only publishes the product; the shifts happen while cnt counts down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      q      <= '0;
      q_1    <= 1'b0;
      mcand  <= '0;
      cnt    <= '0;
      prod_r <= '0;
    end else if (accept) begin
      mcand <= bus.Mcand;
      q     <= bus.Mplier;
      acc   <= '0;
      q_1   <= 1'b0;
      cnt   <= CW'(WIDTH);
    end else if (state == RUN) begin
      if (cnt != '0) begin
        acc <= {sum[WIDTH], sum[WIDTH:1]};
        q   <= {sum[0], q[WIDTH-1:1]};
        q_1 <= q[0];
        cnt <= cnt - CW'(1);
      end else begin
        prod_r <= prod_fin;
      end
    end
  end

`ifdef MULT_OVF_FLAG_EN
  logic ovf_r;
  logic ovf_fin;

  assign ovf_fin = !((&prod_fin[2*WIDTH-1:WIDTH-1]) || (~|prod_fin[2*WIDTH-1:WIDTH-1]));
  assign bus.ovf = ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if ((state == RUN) && (cnt == '0)) begin
      ovf_r <= ovf_fin;
    end
  end
`endif

endmodule

// File: tb/tb_booth_seq_mult.sv
// tb/tb_booth_seq_mult.sv - scoreboard bench for booth_seq_mult at WIDTH=5 and WIDTH=16
module tb_booth_seq_mult;
  typedef struct {
    logic [63:0] p;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;
  logic [63:0] model_a = '0;
  logic [63:0] model_b = '0;

  always #5 clk = ~clk;

  booth_seq_mult_if #(.WIDTH(5))  a();
  booth_seq_mult_if #(.WIDTH(16)) b();

  booth_seq_mult #(.WIDTH(5))  u_a (.clk(clk), .rst_n(rst_n), .bus(a));
  booth_seq_mult #(.WIDTH(16)) u_b (.clk(clk), .rst_n(rst_n), .bus(b));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void push5(input int mc, input int mp);
    int   p;
    exp_t e;
    p = mc * mp;
    e.p   = {54'b0, p[9:0]};
    e.ovf = (p > 15) || (p < -16);
    qa.push_back(e);
  endfunction

  function automatic void push16(input int mc, input int mp);
    int   p;
    exp_t e;
    p = mc * mp;
    e.p   = {32'b0, p[31:0]};
    e.ovf = (p > 32767) || (p < -32768);
    qb.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy_and_done_a", {63'b0, a.busy & a.done}, 64'd0);
      if (a.done) begin
        check("sb_a_nonempty", {63'b0, qa.size() != 0}, 64'd1);
        if (qa.size() != 0) begin
          ea = qa.pop_front();
          check("prod_a", {54'b0, a.out}, ea.p);
`ifdef MULT_OVF_FLAG_EN
          check("ovf_a", {63'b0, a.ovf}, {63'b0, ea.ovf});
`endif
          model_a = ea.p;
        end
      end else begin
        check("hold_a", {54'b0, a.out}, model_a);
      end
      if (b.done) begin
        check("sb_b_nonempty", {63'b0, qb.size() != 0}, 64'd1);
        if (qb.size() != 0) begin
          eb = qb.pop_front();
          check("prod_b", {32'b0, b.out}, eb.p);
`ifdef MULT_OVF_FLAG_EN
          check("ovf_b", {63'b0, b.ovf}, {63'b0, eb.ovf});
`endif
          model_b = eb.p;
        end
      end else begin
        check("hold_b", {32'b0, b.out}, model_b);
      end
    end
  end

  task automatic issue5(input int mc, input int mp);
    a.start  = 1'b1;
    a.Mcand  = mc[4:0];
    a.Mplier = mp[4:0];
    push5(mc, mp);
  endtask

  // k counts negedges after the first RUN cycle; at k==ign a stray start with junk operands is pulsed.
  task automatic wait_done5(input int ign, output int k);
    k = 0;
    while (!a.done && k < 40) begin
      @(negedge clk);
      k++;
      if (k == ign) begin
        a.start  = 1'b1;
        a.Mcand  = 5'($urandom);
        a.Mplier = 5'($urandom);
      end else if (k == ign + 1) begin
        a.start = 1'b0;
      end
    end
  endtask

  task automatic op5(input int mc, input int mp, input int ign);
    int k;
    @(negedge clk);
    issue5(mc, mp);
    @(negedge clk);
    a.start = 1'b0;
    wait_done5(ign, k);
    check("lat5", 64'(k), 64'd6);
    @(negedge clk);
    check("done_pulse5", {63'b0, a.done}, 64'd0);
  endtask

  task automatic op16(input int mc, input int mp);
    int k;
    @(negedge clk);
    b.start  = 1'b1;
    b.Mcand  = mc[15:0];
    b.Mplier = mp[15:0];
    push16(mc, mp);
    @(negedge clk);
    b.start = 1'b0;
    k = 0;
    while (!b.done && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("lat16", 64'(k), 64'd17);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    a.start = 1'b0; a.Mcand = '0; a.Mplier = '0;
    b.start = 1'b0; b.Mcand = '0; b.Mplier = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'b0, a.busy}, 64'd0);
    check("rst_done", {63'b0, a.done}, 64'd0);
    check("rst_out",  {54'b0, a.out}, 64'd0);
    check("rst_out_b", {32'b0, b.out}, 64'd0);
    #2 rst_n = 1'b1;

    op5(-10, 4, -1);
    check("r028_out", {54'b0, a.out}, 64'h3D8);
`ifdef MULT_OVF_FLAG_EN
    check("r028_ovf", {63'b0, a.ovf}, 64'd1);
`endif
    op5(-16, -16, -1);
    check("r030_a", {54'b0, a.out}, 64'h100);
    op5(3, -5, -1);
    check("r030_b", {54'b0, a.out}, 64'h3F1);
`ifdef MULT_OVF_FLAG_EN
    check("r030_ovf", {63'b0, a.ovf}, 64'd0);
`endif

    // Back-to-back: start held in DONE launches the second product with no idle cycle.
    @(negedge clk);
    issue5(11, -3);
    @(negedge clk);
    a.start = 1'b0;
    wait_done5(-1, k);
    check("lat_b2b1", 64'(k), 64'd6);
    check("r029_a", {54'b0, a.out}, 64'h3DF);
    issue5(-10, -11);
    @(negedge clk);
    check("b2b_busy", {63'b0, a.busy}, 64'd1);
    check("b2b_done", {63'b0, a.done}, 64'd0);
    a.start = 1'b0;
    wait_done5(-1, k);
    check("lat_b2b2", 64'(k), 64'd6);
    check("r029_b", {54'b0, a.out}, 64'h06E);
    @(negedge clk);

    op5(9, -7, 2);
    check("r031_out", {54'b0, a.out}, 64'h3C1);

    // Abort in the second RUN cycle, then start on the first edge after release.
    @(negedge clk);
    a.start = 1'b1; a.Mcand = 5'd5; a.Mplier = 5'd9;
    @(negedge clk);
    a.start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_a = '0;
    model_b = '0;
    #1;
    check("abort_busy", {63'b0, a.busy}, 64'd0);
    check("abort_done", {63'b0, a.done}, 64'd0);
    check("abort_out",  {54'b0, a.out}, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    issue5(7, 2);
    @(negedge clk);
    a.start = 1'b0;
    wait_done5(-1, k);
    check("lat_post_rst", 64'(k), 64'd6);
    check("r032_out", {54'b0, a.out}, 64'h00E);
    @(negedge clk);

    for (int mc = -16; mc < 16; mc++) begin
      for (int mp = -16; mp < 16; mp++) begin
        op5(mc, mp, -1);
      end
    end

    op16(-32768, -32768);
    op16(32767, -32768);
    for (int i = 0; i < 1000; i++) begin
      op16(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
    end

    repeat (3) @(negedge clk);
    check("sb_a_drained", 64'(qa.size()), 64'd0);
    check("sb_b_drained", 64'(qb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
